// File: rtl/uart_pkg.sv
// UART shared types: parity selection, TX/RX FSM states,
// parameter legality check and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic bit params_ok(
    input int clk_div,
    input int os,
    input int dbits,
    input int pmode,
    input int sbits
  );
    return (clk_div >= 1) && (os >= 4) && (os % 2 == 0) &&
           (dbits >= 5) && (dbits <= 9) &&
           (pmode >= 0) && (pmode <= 2) &&
           ((sbits == 1) || (sbits == 2));
  endfunction

  // Payload is zero-extended to 9 bits; zeros do not change parity.
  function automatic logic parity_of(
    input logic [8:0]   d,
    input parity_mode_e m
  );
    logic p;
    p = 1'b0;
    if (m == PAR_EVEN) p = ^d;
    else if (m == PAR_ODD) p = ~^d;
    return p;
  endfunction

endpackage

// File: rtl/uart_core_param_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks,
// restartable so a bit period lines up with a frame start.
module uart_baud_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex parametrised UART: TX serialiser, oversampling RX
// deserialiser with error flags, and an internal loopback mux.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 loopback_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  if (!params_ok(CLK_DIV, OVERSAMPLE, DATA_BITS,
                 PARITY_MODE, STOP_BITS)) begin : g_bad_params
    $error("uart_core_param: illegal parameter set");
  end

  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
  localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE);
  localparam bit PAR_EN = (PARITY_MODE != 0);

  // ---------------- TX ----------------
  tx_state_e            tx_state, tx_state_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n;
  logic [OW-1:0]        tx_os, tx_os_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic                 tx_clr, tx_tick, tx_end;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tx_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tx_clr),
    .tick  (tx_tick)
  );

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_end   = tx_tick && (tx_os == OS_LAST);

  always_comb begin
    tx_state_n = tx_state;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_clr     = 1'b0;
    if (tx_tick) begin
      tx_os_n = (tx_os == OS_LAST) ? '0 : tx_os + OW'(1);
    end
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_sh_n    = tx_data;
          tx_par_n   = parity_of(9'(tx_data), PMODE);
          tx_os_n    = '0;
          tx_bit_n   = '0;
          tx_clr     = 1'b1;
        end
      end
      TX_START: begin
        if (tx_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        if (tx_end) begin
          tx_sh_n = tx_sh >> 1;
          if (tx_bit == DB_LAST) begin
            tx_bit_n   = '0;
            tx_state_n = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_n = tx_bit + 4'd1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_end) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_end) begin
          if (tx_bit == SB_LAST) tx_state_n = TX_IDLE;
          else tx_bit_n = tx_bit + 4'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_os    <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
    end
  end

  // Decoded from state so reset drives the line high immediately.
  always_comb begin
    tx = 1'b1;
    unique case (tx_state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_sh[0];
      TX_PARITY: tx = tx_par;
      default:   tx = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic rx_in, s1, s2, s3;

  assign rx_in = loopback_en ? tx : rx;

  // s3 only holds the previous synchronised level for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  rx_state_e            rx_state, rx_state_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_pbit, rx_pbit_n;
  logic [OW-1:0]        rx_os, rx_os_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic                 rx_clr, rx_tick, rx_mid, rx_end;
  logic                 rx_done;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_rx_tick (
    .clk   (clk),
    .reset (reset),
    .clear (rx_clr),
    .tick  (rx_tick)
  );

  assign rx_mid = rx_tick && (rx_os == OS_HALF);
  assign rx_end = rx_tick && (rx_os == OS_LAST);

  always_comb begin
    rx_state_n = rx_state;
    rx_sh_n    = rx_sh;
    rx_pbit_n  = rx_pbit;
    rx_os_n    = rx_os;
    rx_bit_n   = rx_bit;
    rx_clr     = 1'b0;
    rx_done    = 1'b0;
    if (rx_tick) begin
      rx_os_n = (rx_os == OS_LAST) ? '0 : rx_os + OW'(1);
    end
    unique case (rx_state)
      RX_IDLE: begin
        if (s3 && !s2) begin
          rx_state_n = RX_START;
          rx_os_n    = '0;
          rx_clr     = 1'b1;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          rx_os_n    = '0;
          rx_bit_n   = '0;
          rx_state_n = s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_end) begin
          rx_sh_n = {s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == DB_LAST) begin
            rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_end) begin
          rx_pbit_n  = s2;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_end) begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
      rx_os    <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_sh    <= rx_sh_n;
      rx_pbit  <= rx_pbit_n;
      rx_os    <= rx_os_n;
      rx_bit   <= rx_bit_n;
    end
  end

  logic consume, load, frame_perr;

  assign consume    = rx_valid && rx_ready;
  assign load       = rx_done && (!rx_valid || rx_ready);
  assign frame_perr = PAR_EN &&
                      (rx_pbit != parity_of(9'(rx_sh), PMODE));

  // A completing frame takes priority over a same-cycle consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (load) begin
      rx_data       <= rx_sh;
      rx_valid      <= 1'b1;
      rx_parity_err <= frame_perr;
      rx_frame_err  <= !s2;
      rx_overrun    <= 1'b0;
    end else begin
      if (rx_done) rx_overrun <= 1'b1;
      if (consume) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
        rx_overrun    <= 1'b0;
      end
    end
  end

endmodule
